// File: rtl/dff_bank_checker_if.sv
// Stimulus and result bundle shared between the bank harness and the checker.
// The harness side (master) drives the bank stimulus and the observed q;
// the checker side (slave) consumes them and returns the verdict.
interface dff_bank_checker_if #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8,
    parameter int CYC_W = 16
);
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] d;
    logic             en;
    logic             pre;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             pass;
    logic             fail;
    logic [ERR_W-1:0] err_cnt;
    logic [WIDTH-1:0] first_err_q;
    logic [CYC_W-1:0] first_err_cyc;

    modport master (
        output start, stop, d, en, pre, q,
        input  busy, pass, fail, err_cnt, first_err_q, first_err_cyc
    );

    modport slave (
        input  start, stop, d, en, pre, q,
        output busy, pass, fail, err_cnt, first_err_q, first_err_cyc
    );
endinterface

// File: rtl/dff_bank_checker.sv
// Cycle-accurate checker for a flop bank with sync active-low preset and enable.
// A reference copy of the bank is clocked from the same stimulus and compared
// against the observed q while a run is active.
//
// state  | meaning
// IDLE   | no run since reset, waiting for start
// SETTLE | run started, letting the bank settle; no comparisons
// RUN    | comparing q against the reference every cycle
// DONE   | run ended, verdict held until the next start
module dff_bank_checker #(
    parameter int WIDTH  = 4,
    parameter int ERR_W  = 8,
    parameter int CYC_W  = 16,
    parameter int SETTLE = 2
) (
    input  logic               clk,
    input  logic               clr,
    dff_bank_checker_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0]       SETTLE_LD = 4'(SETTLE);
    localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};
    localparam logic [CYC_W-1:0] CYC_MAX   = {CYC_W{1'b1}};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_exp;
    logic [3:0]       r_settle;
    logic [3:0]       w_settle_nxt;
    logic [CYC_W-1:0] r_cyc;
    logic [CYC_W-1:0] w_cyc_nxt;
    logic [ERR_W-1:0] r_err;
    logic [ERR_W-1:0] w_err_nxt;
    logic             r_fail;
    logic             w_fail_nxt;
    logic [WIDTH-1:0] r_feq;
    logic [WIDTH-1:0] w_feq_nxt;
    logic [CYC_W-1:0] r_fec;
    logic [CYC_W-1:0] w_fec_nxt;
    logic             r_busy;
    logic             r_pass;
    logic             w_clear;
    logic             w_mismatch;

    assign w_mismatch = (bus.q != r_exp);

    // Reference bank: same priority as the real one, preset over enable.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_exp <= '0;
        end else if (!bus.pre) begin
            r_exp <= '1;
        end else if (bus.en) begin
            r_exp <= bus.d;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and result update; stop beats start once a run is active.
    always_comb begin
        w_state_nxt  = r_state;
        w_settle_nxt = r_settle;
        w_cyc_nxt    = r_cyc;
        w_err_nxt    = r_err;
        w_fail_nxt   = r_fail;
        w_feq_nxt    = r_feq;
        w_fec_nxt    = r_fec;
        w_clear      = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    w_state_nxt = ST_SETTLE;
                    w_clear     = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (bus.stop) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_settle_nxt = r_settle - 4'd1;
                    if (r_settle <= 4'd1) begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (r_cyc != CYC_MAX) begin
                    w_cyc_nxt = r_cyc + 1'b1;
                end
                if (w_mismatch) begin
                    if (r_err != ERR_MAX) begin
                        w_err_nxt = r_err + 1'b1;
                    end
                    w_fail_nxt = 1'b1;
                    // fail is cleared at start, so a low fail marks the first error
                    if (!r_fail) begin
                        w_feq_nxt = bus.q;
                        w_fec_nxt = r_cyc;
                    end
                end
                if (bus.stop) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_clear) begin
            w_settle_nxt = SETTLE_LD;
            w_cyc_nxt    = '0;
            w_err_nxt    = '0;
            w_fail_nxt   = 1'b0;
            w_feq_nxt    = '0;
            w_fec_nxt    = '0;
        end
    end

    // Result registers; busy and pass are decoded from the next state so they
    // line up with r_state.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_settle <= '0;
            r_cyc    <= '0;
            r_err    <= '0;
            r_fail   <= 1'b0;
            r_feq    <= '0;
            r_fec    <= '0;
            r_busy   <= 1'b0;
            r_pass   <= 1'b0;
        end else begin
            r_settle <= w_settle_nxt;
            r_cyc    <= w_cyc_nxt;
            r_err    <= w_err_nxt;
            r_fail   <= w_fail_nxt;
            r_feq    <= w_feq_nxt;
            r_fec    <= w_fec_nxt;
            r_busy   <= (w_state_nxt == ST_SETTLE) || (w_state_nxt == ST_RUN);
            r_pass   <= (w_state_nxt == ST_DONE) && (w_err_nxt == '0);
        end
    end

    assign bus.busy          = r_busy;
    assign bus.pass          = r_pass;
    assign bus.fail          = r_fail;
    assign bus.err_cnt       = r_err;
    assign bus.first_err_q   = r_feq;
    assign bus.first_err_cyc = r_fec;
endmodule

// File: doc/dff_bank_checker.md
Name: dff_bank_checker

Overview:
- Downstream consumer of a WIDTH-bit flop bank with sync active-low preset and enable.
- Runs a cycle-accurate reference model of that bank from the same d/en/pre stimulus and compares it against the bank's q every cycle.
- Counts mismatches and reports a pass/fail verdict with first-error capture.
- Sits beside the flop bank in the top-level harness, reading its q output.

Parameters:
- WIDTH, 4, data width of the observed flop bank.
- ERR_W, 8, width of the saturating mismatch counter.
- CYC_W, 16, width of the saturating run-cycle counter.
- SETTLE, 2, cycles after start before comparison begins (1..15).

Ports:
- clk  input  1  rising-edge clock shared with the observed bank.
- clr  input  1  asynchronous active-low reset for the whole block.
- start  input  1  pulse: clear results and begin a check run.
- stop  input  1  pulse: end the current run.
- d  input  WIDTH  data stimulus driven to the bank.
- en  input  1  enable stimulus driven to the bank.
- pre  input  1  sync active-low preset stimulus driven to the bank.
- q  input  WIDTH  observed bank output.
- busy  output  1  high in SETTLE or RUN.
- pass  output  1  high in DONE when err_cnt==0.
- fail  output  1  sticky; high from the cycle after the first mismatch until the next start or reset.
- err_cnt  output  ERR_W  mismatch count, saturating.
- first_err_q  output  WIDTH  q value at the first mismatch.
- first_err_cyc  output  CYC_W  run-cycle index of the first mismatch.

Behaviour:
- Reset (clr low, asynchronous):
  - state=IDLE; model register exp=0.
  - All outputs 0: busy, pass, fail, err_cnt, first_err_q, first_err_cyc.
  - Run counter cyc=0; settle counter=0.
- Model, updated every rising edge regardless of state:
  - if pre==0, exp <= all ones;
  - else if en==1, exp <= d;
  - else exp holds.
  - exp therefore tracks the bank with zero relative latency: both update on the same edge.
- Compare: mismatch = (q != exp), evaluated on the current registered values. It is acted on only in RUN.
- FSM, four states IDLE / SETTLE / RUN / DONE:
  - IDLE: start -> SETTLE. The transition clears err_cnt, fail, pass, first_err_*, cyc and loads the settle counter with SETTLE.
  - SETTLE: settle counter decrements each cycle; on reaching 0 -> RUN. No comparisons. stop -> DONE.
  - RUN: each cycle cyc increments, saturating at 2^CYC_W-1. On mismatch, err_cnt increments, saturating at 2^ERR_W-1, and fail <= 1. On the first mismatch of the run, first_err_q <= q and first_err_cyc <= cyc (the pre-increment value). stop -> DONE.
  - DONE: pass = (err_cnt==0), held. start -> SETTLE, clearing results as from IDLE.
- Simultaneous events:
  - start and stop in the same cycle: start wins in IDLE and DONE; stop wins in SETTLE and RUN.
  - Mismatch in the same cycle as stop in RUN: the mismatch is counted, then DONE.
  - start while in SETTLE or RUN is ignored.
- Saturation: err_cnt and cyc stop at their maximum and never wrap. fail stays set.
- Reset mid-run: everything returns to reset values immediately. The model restarts from exp=0, matching the bank's own zeroed state.
- busy is a registered decode of state. pass is valid only in DONE and is 0 in all other states.

Test Plan:
- Reset, pre=1, en=1, d=4'hA from cycle 0, q driven by a correct bank; start, wait SETTLE, run 20 cycles, stop -> DONE, pass=1, fail=0, err_cnt=0.
- Correct bank, pre pulsed low for 1 cycle mid-run with en=0 -> q and exp both 4'hF, no mismatch, pass=1.
- Bank with bit0 stuck at 0, d=4'h5, en=1, 10 RUN cycles -> fail=1 from the first compare, err_cnt=10, first_err_q=4'h4, first_err_cyc=0, pass=0 after stop.
- Forced permanent mismatch for 300 RUN cycles with ERR_W=8 -> err_cnt=255 saturated, fail=1.
- Mismatch injected only on the cycle stop is asserted -> err_cnt=1, state DONE, pass=0; start and stop together in DONE -> SETTLE with all results cleared.
- clr asserted low mid-RUN with err_cnt=3 -> all outputs 0 and state IDLE immediately; after release, start plus a correct bank -> pass=1.
